// File: rtl/light_monitor_pkg.sv
// light_monitor_pkg: phase and light codes shared by the traffic controller and its monitor.
package light_monitor_pkg;
    localparam logic [1:0] PH_AG_BR = 2'd0;
    localparam logic [1:0] PH_AY_BR = 2'd1;
    localparam logic [1:0] PH_AR_BG = 2'd2;
    localparam logic [1:0] PH_AR_BY = 2'd3;
    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;
    typedef enum logic {ST_SYNC, ST_TRACK} mon_state_e;
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic ta, input logic tb);
        return phase == PH_AG_BR ? (ta ? PH_AG_BR : PH_AY_BR) :
               phase == PH_AY_BR ? PH_AR_BG :
               phase == PH_AR_BG ? (tb ? PH_AR_BG : PH_AR_BY) : PH_AG_BR;
    endfunction
endpackage

// File: rtl/light_decode.sv
// light_decode: maps the two road lights to a controller phase and flags illegal combinations.
module light_decode
    import light_monitor_pkg::*;
(
    input  logic [1:0] la_i,
    input  logic [1:0] lb_i,
    output logic       legal_o,
    output logic [1:0] phase_o
);
    assign legal_o = (la_i == GREEN  && lb_i == RED) || (la_i == YELLOW && lb_i == RED) ||
                     (la_i == RED    && lb_i == GREEN) || (la_i == RED && lb_i == YELLOW);
    assign phase_o = la_i == YELLOW ? PH_AY_BR :
                     lb_i == GREEN  ? PH_AR_BG :
                     lb_i == YELLOW ? PH_AR_BY : PH_AG_BR;
endmodule

// File: rtl/light_monitor.sv
// light_monitor: passive checker rebuilding the controller phase from its lights,
// with sticky encoding/sequence/starvation errors and a completed-cycle counter.
module light_monitor
    import light_monitor_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_GREEN = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ta_i,
    input  logic             tb_i,
    input  logic             la1_i,
    input  logic             la0_i,
    input  logic             lb1_i,
    input  logic             lb0_i,
    output logic [1:0]       phase_o,
    output logic             synced_o,
    output logic             err_enc_o,
    output logic             err_seq_o,
    output logic             err_starve_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);
    mon_state_e       state_q, state_d;
    logic [1:0]       phase_q, phase_d, obs, exp_ph;
    logic             legal, synced_q, synced_d, prev_ta_q, prev_tb_q;
    logic             err_enc_q, err_enc_d, err_seq_q, err_seq_d, err_starve_q, err_starve_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;

    light_decode u_decode (
        .la_i   ({la1_i, la0_i}),
        .lb_i   ({lb1_i, lb0_i}),
        .legal_o(legal),
        .phase_o(obs)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        synced_d     = synced_q;
        err_enc_d    = err_enc_q | ~legal;
        err_seq_d    = err_seq_q;
        err_starve_d = err_starve_q;
        cnt_d        = cnt_q;
        dwell_d      = dwell_q;
        exp_ph       = next_phase(phase_q, prev_ta_q, prev_tb_q);
        if (state_q == ST_SYNC) begin
            if (legal) begin
                state_d  = ST_TRACK;
                phase_d  = obs;
                synced_d = 1'b1;
                dwell_d  = '0;
            end
        end else begin
            if (legal) begin
                phase_d   = obs;
                err_seq_d = err_seq_q | (obs != exp_ph);
                cnt_d     = (phase_q == PH_AR_BY && obs == PH_AG_BR && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
            end
            dwell_d      = phase_d != phase_q ? '0 : (dwell_q == '1 ? dwell_q : dwell_q + CNT_W'(1));
            // starvation is judged against the sensor the controller actually saw last edge
            err_starve_d = err_starve_q | (dwell_d >= CNT_W'(MAX_GREEN) &&
                           ((phase_d == PH_AG_BR && !prev_ta_q) || (phase_d == PH_AR_BG && !prev_tb_q)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_SYNC;
            phase_q      <= PH_AG_BR;
            synced_q     <= 1'b0;
            err_enc_q    <= 1'b0;
            err_seq_q    <= 1'b0;
            err_starve_q <= 1'b0;
            cnt_q        <= '0;
            dwell_q      <= '0;
            prev_ta_q    <= 1'b0;
            prev_tb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            synced_q     <= synced_d;
            err_enc_q    <= err_enc_d;
            err_seq_q    <= err_seq_d;
            err_starve_q <= err_starve_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            prev_ta_q    <= ta_i;
            prev_tb_q    <= tb_i;
        end
    end

    assign phase_o      = phase_q;
    assign synced_o     = synced_q;
    assign err_enc_o    = err_enc_q;
    assign err_seq_o    = err_seq_q;
    assign err_starve_o = err_starve_q;
    assign cycle_cnt_o  = cnt_q;
endmodule
